// File: rtl/tl_pkg.sv
// Shared types and lamp encodings for the intersection phase controllers.
// Lamp vectors are written {red, yellow, green}, so LAMP_RED is 3'b100.
package tl_pkg;

  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    GREEN   = 3'd1,
    YELLOW  = 3'd2,
    FLASH   = 3'd3
  } phase_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic logic [2:0] way_lamp(input phase_t ph, input logic is_active,
                                          input logic flash);
    logic [2:0] lamp;
    case (ph)
      ALL_RED: lamp = LAMP_RED;
      GREEN:   lamp = is_active ? LAMP_GRN : LAMP_RED;
      YELLOW:  lamp = is_active ? LAMP_YEL : LAMP_RED;
      FLASH:   lamp = flash ? LAMP_YEL : LAMP_OFF;
      default: lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/intersection_sequencer_if.sv
// Control and lamp bundle between the timebase/request side and the sequencer.
// The extend_req field exists only when GREEN_EXTEND_EN is defined.
interface intersection_sequencer_if #(
  parameter int N_WAYS = 4
);
  localparam int AW_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

  logic                   tick;
  logic                   attention;
  logic [N_WAYS-1:0]      preferential;
  logic [N_WAYS-1:0]      force_red;
`ifdef GREEN_EXTEND_EN
  logic [N_WAYS-1:0]      extend_req;
`endif
  logic [N_WAYS-1:0][2:0] ltfs;
  logic [N_WAYS-1:0]      lgreen;
  logic [AW_W-1:0]        active_way;
  logic [2:0]             phase;

`ifdef GREEN_EXTEND_EN
  modport master (output tick, attention, preferential, force_red, extend_req,
                  input  ltfs, lgreen, active_way, phase);
  modport slave  (input  tick, attention, preferential, force_red, extend_req,
                  output ltfs, lgreen, active_way, phase);
`else
  modport master (output tick, attention, preferential, force_red,
                  input  ltfs, lgreen, active_way, phase);
  modport slave  (input  tick, attention, preferential, force_red,
                  output ltfs, lgreen, active_way, phase);
`endif

endinterface

// File: rtl/way_selector.sv
// Picks the next approach to grant: lowest-index eligible preferential way,
// otherwise the first eligible way cyclically after active_way (itself last).
module way_selector #(
  parameter int N_WAYS = 4,
  parameter int AW_W   = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
  input  logic [AW_W-1:0]   active_way,
  input  logic [N_WAYS-1:0] preferential,
  input  logic [N_WAYS-1:0] force_red,
  output logic              valid,
  output logic [AW_W-1:0]   next_idx
);

  logic [N_WAYS-1:0] eligible_s;
  logic              pref_hit_s;
  logic [AW_W-1:0]   pref_idx_s;
  logic              rr_hit_s;
  logic [AW_W-1:0]   rr_idx_s;
  int                cand_s;

  // Priority scans; iterating downward lets the nearest candidate win.
  always_comb begin
    eligible_s = ~force_red;
    pref_hit_s = 1'b0;
    pref_idx_s = {AW_W{1'b0}};
    rr_hit_s   = 1'b0;
    rr_idx_s   = {AW_W{1'b0}};
    cand_s     = 0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (preferential[i] && eligible_s[i]) begin
        pref_hit_s = 1'b1;
        pref_idx_s = AW_W'(i);
      end else begin
        pref_hit_s = pref_hit_s;
      end
    end
    for (int k = N_WAYS; k >= 1; k--) begin
      cand_s = (int'(active_way) + k) % N_WAYS;
      if (eligible_s[cand_s]) begin
        rr_hit_s = 1'b1;
        rr_idx_s = AW_W'(cand_s);
      end else begin
        rr_hit_s = rr_hit_s;
      end
    end
    valid    = pref_hit_s | rr_hit_s;
    next_idx = pref_hit_s ? pref_idx_s : rr_idx_s;
  end

endmodule

// File: rtl/intersection_sequencer.sv
// N-way intersection phase controller: ALL_RED -> GREEN -> YELLOW rotation plus
// flashing-yellow attention mode. Define GREEN_EXTEND_EN for tick-wise green extension.
module intersection_sequencer
  import tl_pkg::*;
#(
  parameter int N_WAYS       = 4,
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 10,
  parameter int YELLOW_TICKS = 3,
  parameter int CLEAR_TICKS  = 1
`ifdef GREEN_EXTEND_EN
  , parameter int MAX_EXTEND = 5
`endif
) (
  input logic clk,
  input logic rst,
  intersection_sequencer_if.slave bus
);

  localparam int AW_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_TICKS - 1);
  localparam logic [AW_W-1:0]  LAST_WAY    = AW_W'(N_WAYS - 1);

  phase_t                 phase_r, phase_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [AW_W-1:0]        active_r, active_s;
  logic                   flash_r, flash_s;
  logic                   sel_valid_s;
  logic [AW_W-1:0]        sel_idx_s;
  logic [N_WAYS-1:0][2:0] ltfs_r, ltfs_s;
  logic [N_WAYS-1:0]      lgreen_r, lgreen_s;
`ifdef GREEN_EXTEND_EN
  localparam int EXT_W = (MAX_EXTEND > 0) ? $clog2(MAX_EXTEND + 1) : 1;
  localparam logic [EXT_W-1:0] EXT_MAX = EXT_W'(MAX_EXTEND);
  logic [EXT_W-1:0] ext_r, ext_s;
`endif

  way_selector #(.N_WAYS(N_WAYS), .AW_W(AW_W)) u_way_selector (
    .active_way   (active_r),
    .preferential (bus.preferential),
    .force_red    (bus.force_red),
    .valid        (sel_valid_s),
    .next_idx     (sel_idx_s)
  );

  // Next-state: attention overrides force_red, which overrides dwell expiry.
  always_comb begin
    phase_s  = phase_r;
    cnt_s    = cnt_r;
    active_s = active_r;
    flash_s  = flash_r;
`ifdef GREEN_EXTEND_EN
    ext_s    = ext_r;
`endif
    if (bus.attention) begin
      if (phase_r != FLASH) begin
        phase_s = FLASH;
        cnt_s   = CNT_ZERO;
      end else if (bus.tick) begin
        flash_s = ~flash_r;
      end else begin
        flash_s = flash_r;
      end
    end else begin
      case (phase_r)
        ALL_RED: begin
          // With no eligible way the counter stays at its last value, so every tick re-selects.
          if (bus.tick && (cnt_r == CLEAR_LAST)) begin
            if (sel_valid_s) begin
              phase_s  = GREEN;
              active_s = sel_idx_s;
              cnt_s    = CNT_ZERO;
`ifdef GREEN_EXTEND_EN
              ext_s    = {EXT_W{1'b0}};
`endif
            end else begin
              cnt_s = cnt_r;
            end
          end else if (bus.tick) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_s = cnt_r;
          end
        end
        GREEN: begin
          if (bus.force_red[active_r]) begin
            phase_s = YELLOW;
            cnt_s   = CNT_ZERO;
          end else if (bus.tick && (cnt_r == GREEN_LAST)) begin
`ifdef GREEN_EXTEND_EN
            if (bus.extend_req[active_r] && (ext_r < EXT_MAX)) begin
              ext_s = ext_r + EXT_W'(1);
            end else begin
              phase_s = YELLOW;
              cnt_s   = CNT_ZERO;
            end
`else
            phase_s = YELLOW;
            cnt_s   = CNT_ZERO;
`endif
          end else if (bus.tick) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_s = cnt_r;
          end
        end
        YELLOW: begin
          if (bus.tick && (cnt_r == YELLOW_LAST)) begin
            phase_s = ALL_RED;
            cnt_s   = CNT_ZERO;
          end else if (bus.tick) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_s = cnt_r;
          end
        end
        FLASH: begin
          phase_s = ALL_RED;
          cnt_s   = CNT_ZERO;
          flash_s = 1'b0;
        end
        default: begin
          phase_s = ALL_RED;
          cnt_s   = CNT_ZERO;
          flash_s = 1'b0;
        end
      endcase
    end
  end

  // Lamp decode from next state so registered lamps line up with the phase register.
  always_comb begin
    ltfs_s   = {N_WAYS{LAMP_RED}};
    lgreen_s = {N_WAYS{1'b0}};
    for (int i = 0; i < N_WAYS; i++) begin
      ltfs_s[i]   = way_lamp(phase_s, active_s == AW_W'(i), flash_s);
      lgreen_s[i] = (phase_s == GREEN) && (active_s == AW_W'(i));
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r  <= ALL_RED;
      cnt_r    <= CNT_ZERO;
      active_r <= LAST_WAY;
      flash_r  <= 1'b0;
      ltfs_r   <= {N_WAYS{LAMP_RED}};
      lgreen_r <= {N_WAYS{1'b0}};
`ifdef GREEN_EXTEND_EN
      ext_r    <= {EXT_W{1'b0}};
`endif
    end else begin
      phase_r  <= phase_s;
      cnt_r    <= cnt_s;
      active_r <= active_s;
      flash_r  <= flash_s;
      ltfs_r   <= ltfs_s;
      lgreen_r <= lgreen_s;
`ifdef GREEN_EXTEND_EN
      ext_r    <= ext_s;
`endif
    end
  end

  assign bus.ltfs       = ltfs_r;
  assign bus.lgreen     = lgreen_r;
  assign bus.active_way = active_r;
  assign bus.phase      = phase_r;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed bench for intersection_sequencer (4 ways, default dwell times).
module tb_intersection_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  intersection_sequencer_if #(.N_WAYS(4)) bus ();

  intersection_sequencer #(.N_WAYS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef GREEN_EXTEND_EN
  initial bus.extend_req = 4'b0000;
`endif

  // Hand-computed lamp words, way0 in bits [2:0], each lamp {red,yellow,green}.
  logic [11:0] grn_lt [4] = '{12'h921, 12'h90C, 12'h864, 12'h324};
  logic [11:0] yel_lt [4] = '{12'h922, 12'h914, 12'h8A4, 12'h524};
  localparam logic [11:0] ALLRED_LT = 12'h924;
  localparam logic [11:0] FLASH_ON  = 12'h492;
  localparam logic [11:0] FLASH_OFF = 12'h000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic t);
    bus.tick = t;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0);
      cycle(1'b0);
      cycle(1'b0);
      cycle(1'b1);
    end
  endtask

  task automatic exp_green(input string tag, input int w);
    chk({tag, ".phase"}, 32'(bus.phase), 32'd1);
    chk({tag, ".way"}, 32'(bus.active_way), 32'(w));
    chk({tag, ".lgreen"}, 32'(bus.lgreen), 32'(1 << w));
    chk({tag, ".ltfs"}, 32'(bus.ltfs), 32'(grn_lt[w]));
  endtask

  task automatic exp_yellow(input string tag, input int w);
    chk({tag, ".phase"}, 32'(bus.phase), 32'd2);
    chk({tag, ".way"}, 32'(bus.active_way), 32'(w));
    chk({tag, ".lgreen"}, 32'(bus.lgreen), 32'd0);
    chk({tag, ".ltfs"}, 32'(bus.ltfs), 32'(yel_lt[w]));
  endtask

  task automatic exp_allred(input string tag, input int w);
    chk({tag, ".phase"}, 32'(bus.phase), 32'd0);
    chk({tag, ".way"}, 32'(bus.active_way), 32'(w));
    chk({tag, ".lgreen"}, 32'(bus.lgreen), 32'd0);
    chk({tag, ".ltfs"}, 32'(bus.ltfs), 32'(ALLRED_LT));
  endtask

  // At most one green lamp at any time.
  always @(negedge clk) begin
    chk("onehot0", 32'($onehot0(bus.lgreen)), 32'd1);
  end

  int rot [3] = '{2, 3, 0};

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.attention = 1'b0;
    bus.preferential = 4'b0000;
    bus.force_red = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_allred("reset", 3);
    rst = 1'b0;

    // Basic dwell: first selection is way0, then 10 green / 3 yellow / 1 all-red.
    do_ticks(1);
    exp_green("g0", 0);
    do_ticks(9);
    exp_green("g0_last", 0);
    do_ticks(1);
    exp_yellow("y0", 0);
    do_ticks(2);
    exp_yellow("y0_last", 0);
    do_ticks(1);
    exp_allred("r0", 0);
    do_ticks(1);
    exp_green("g1", 1);
    for (int j = 0; j < 3; j++) begin
      do_ticks(10);
      exp_yellow("rot_y", (rot[j] + 3) % 4);
      do_ticks(3);
      exp_allred("rot_r", (rot[j] + 3) % 4);
      do_ticks(1);
      exp_green("rot_g", rot[j]);
    end

    // Preferential way2 overrides rotation to way1.
    do_ticks(10);
    exp_yellow("p_y0", 0);
    bus.preferential = 4'b0100;
    do_ticks(3);
    exp_allred("p_r", 0);
    do_ticks(1);
    exp_green("p_g2", 2);
    bus.preferential = 4'b0000;

    // Bring way1 up via preference, then force it red mid-green.
    do_ticks(10);
    bus.preferential = 4'b0010;
    do_ticks(4);
    exp_green("p_g1", 1);
    bus.preferential = 4'b0000;
    do_ticks(5);
    bus.force_red = 4'b0010;
    cycle(1'b0);
    exp_yellow("fr_y1", 1);
    do_ticks(3);
    exp_allred("fr_r", 1);
    do_ticks(1);
    exp_green("fr_g2", 2);
    bus.force_red = 4'b0000;

    // All ways forced red: hold in all-red until one is released.
    bus.force_red = 4'b1111;
    cycle(1'b0);
    exp_yellow("all_y2", 2);
    do_ticks(3);
    exp_allred("all_r", 2);
    do_ticks(3);
    exp_allred("all_hold", 2);
    bus.force_red = 4'b0111;
    do_ticks(1);
    exp_green("rel_g3", 3);
    bus.force_red = 4'b0000;

    // Attention during way0 green.
    do_ticks(14);
    exp_green("a_g0", 0);
    do_ticks(3);
    bus.attention = 1'b1;
    cycle(1'b0);
    chk("fl.phase", 32'(bus.phase), 32'd3);
    chk("fl.lgreen", 32'(bus.lgreen), 32'd0);
    chk("fl.off0", 32'(bus.ltfs), 32'(FLASH_OFF));
    do_ticks(1);
    chk("fl.on", 32'(bus.ltfs), 32'(FLASH_ON));
    do_ticks(1);
    chk("fl.off1", 32'(bus.ltfs), 32'(FLASH_OFF));
    bus.attention = 1'b0;
    cycle(1'b0);
    exp_allred("fl_exit", 0);
    do_ticks(1);
    exp_green("fl_g1", 1);

    // Asynchronous reset in the middle of yellow.
    do_ticks(10);
    exp_yellow("rs_y1", 1);
    do_ticks(1);
    #2;
    rst = 1'b1;
    #1;
    exp_allred("async_rst", 3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_ticks(1);
    exp_green("rs_g0", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
